imm_packer: RTL and testbench

Streaming instruction encoder: the inverse of the core's immediate extraction. It takes a base instruction word with the immediate fields don't-care plus a 32-bit immediate, and packs the immediate into the I/S/B/U/J bit positions, flagging unencodable values. It also expands the `li rd, imm` pseudo-instruction into one or two words: LUI and/or ADDI. It sits between the debug/BIOS stub generator and the instruction-memory write port, with valid/ready on both sides.

---
 rtl/imm_packer_if.sv | 25 ++
 rtl/imm_packer.sv | 148 ++++++++++++++
 tb/tb_imm_packer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_packer_if.sv
// Request/response bundle for the immediate packer: request side in_*, emitted-word side out_*.
// The packer takes the slave modport; the stub generator / imem writer side takes master.
interface imm_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [2:0]  in_imm_type;
  logic        in_li;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        out_last;

  modport master (
    output in_valid, in_base, in_imm, in_imm_type, in_li, out_ready,
    input  in_ready, out_valid, out_inst, out_err, out_last
  );

  modport slave (
    input  in_valid, in_base, in_imm, in_imm_type, in_li, out_ready,
    output in_ready, out_valid, out_inst, out_err, out_last
  );
endinterface

// File: rtl/imm_packer.sv
// Streaming instruction encoder: packs an immediate into I/S/B/U/J fields of a base word,
// or expands li rd, imm into ADDI, LUI, or LUI+ADDI.
//
// state | meaning
// IDLE  | output register free or holding a final word; requests may be accepted
// EMIT2 | LUI of a two-word li is in the output register, ADDI waiting in pend_inst
module imm_packer (
  input logic        clk,
  input logic        rst_n,
  imm_packer_if.slave bus
);

  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] U_TYPE = 3'd3;
  localparam logic [2:0] J_TYPE = 3'd4;

  typedef enum logic {IDLE, EMIT2} state_t;

  state_t      state;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic        out_err_q;
  logic        out_last_q;
  logic [31:0] pend_inst;

  logic        accept;
  logic        out_fire;

  logic [31:0] imm;
  logic [31:0] base;
  logic [4:0]  rd;
  logic [11:0] lo;
  logic [19:0] hi;
  logic        fits12;
  logic        fits13;
  logic        fits21;

  logic [31:0] enc_inst;
  logic        enc_err;
  logic        enc_two;
  logic [31:0] enc_pend;

  assign imm  = bus.in_imm;
  assign base = bus.in_base;
  assign rd   = bus.in_base[11:7];
  assign lo   = bus.in_imm[11:0];
  // ADDI sign-extends lo, so the upper part absorbs a borrow when lo is negative
  assign hi   = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};

  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  always_comb begin
    enc_inst = base;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    enc_pend = 32'd0;
    if (bus.in_li) begin
      if (fits12) begin
        enc_inst = {lo, 5'd0, 3'b000, rd, 7'h13};
      end else if (lo == 12'd0) begin
        enc_inst = {hi, rd, 7'h37};
      end else begin
        enc_inst = {hi, rd, 7'h37};
        enc_two  = 1'b1;
        enc_pend = {lo, rd, 3'b000, rd, 7'h13};
      end
    end else begin
      case (bus.in_imm_type)
        I_TYPE: begin
          enc_inst = (base & 32'h000F_FFFF) | {imm[11:0], 20'd0};
          enc_err  = ~fits12;
        end
        S_TYPE: begin
          enc_inst = (base & 32'h01FF_F07F) | {imm[11:5], 13'd0, imm[4:0], 7'd0};
          enc_err  = ~fits12;
        end
        B_TYPE: begin
          enc_inst = (base & 32'h01FF_F07F)
                   | {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
          enc_err  = imm[0] | ~fits13;
        end
        U_TYPE: begin
          enc_inst = (base & 32'h0000_0FFF) | {imm[31:12], 12'd0};
          enc_err  = (imm[11:0] != 12'd0);
        end
        J_TYPE: begin
          enc_inst = (base & 32'h0000_0FFF)
                   | {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
          enc_err  = imm[0] | ~fits21;
        end
        default: begin
          enc_inst = base;
          enc_err  = 1'b1;
        end
      endcase
    end
  end

  assign out_fire     = out_valid_q & bus.out_ready;
  assign bus.in_ready = (state == IDLE) & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      pend_inst   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= enc_inst;
            out_err_q   <= enc_err;
            out_last_q  <= ~enc_two;
            pend_inst   <= enc_pend;
            if (enc_two) state <= EMIT2;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
          end
        end
        EMIT2: begin
          // out_valid stays high: the ADDI replaces the LUI in the same slot
          if (out_fire) begin
            out_inst_q <= pend_inst;
            out_err_q  <= 1'b0;
            out_last_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_imm_packer.sv
// Directed and randomized-backpressure bench for imm_packer.
module tb_imm_packer;

  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] U_TYPE = 3'd3;
  localparam logic [2:0] J_TYPE = 3'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic        last;
  } word_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  word_t exp_q[$];

  imm_packer_if bus();

  imm_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic req(input string tag, input logic [31:0] b, input logic [31:0] imm,
                     input logic [2:0] t, input logic li);
    int n;
    n = 0;
    bus.in_valid    = 1'b1;
    bus.in_base     = b;
    bus.in_imm      = imm;
    bus.in_imm_type = t;
    bus.in_li       = li;
    #0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk({tag, " accept"}, 40'(bus.in_ready), 40'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Checks the word currently offered, then lets it be consumed (out_ready assumed 1).
  task automatic expect_word(input string tag, input logic [31:0] inst,
                             input logic err, input logic last);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " valid"}, 40'(bus.out_valid), 40'd1);
    chk({tag, " inst"},  40'(bus.out_inst),  40'(inst));
    chk({tag, " err"},   40'(bus.out_err),   40'(err));
    chk({tag, " last"},  40'(bus.out_last),  40'(last));
    @(posedge clk); #1;
  endtask

  // Reference: signed range tests and li split as hi = (imm - sext(lo)) >> 12.
  function automatic void model(input logic [31:0] b, input logic [31:0] imm,
                                input logic [2:0] t, input logic li);
    int                 s;
    logic signed [11:0] lo_s;
    int                 lo_i;
    logic [31:0]        up;
    word_t              w;
    s = signed'(imm);
    if (li) begin
      lo_s = imm[11:0];
      lo_i = lo_s;
      up   = imm - 32'(lo_i);
      if (s >= -2048 && s <= 2047) begin
        w = '{{imm[11:0], 5'd0, 3'b000, b[11:7], 7'h13}, 1'b0, 1'b1};
        exp_q.push_back(w);
      end else if (imm[11:0] == 12'd0) begin
        w = '{{up[31:12], b[11:7], 7'h37}, 1'b0, 1'b1};
        exp_q.push_back(w);
      end else begin
        w = '{{up[31:12], b[11:7], 7'h37}, 1'b0, 1'b0};
        exp_q.push_back(w);
        w = '{{imm[11:0], b[11:7], 3'b000, b[11:7], 7'h13}, 1'b0, 1'b1};
        exp_q.push_back(w);
      end
    end else begin
      case (t)
        I_TYPE: w = '{{imm[11:0], b[19:0]}, (s < -2048 || s > 2047), 1'b1};
        S_TYPE: w = '{{imm[11:5], b[24:12], imm[4:0], b[6:0]}, (s < -2048 || s > 2047), 1'b1};
        B_TYPE: w = '{{imm[12], imm[10:5], b[24:12], imm[4:1], imm[11], b[6:0]},
                      (imm[0] || s < -4096 || s > 4094), 1'b1};
        U_TYPE: w = '{{imm[31:12], b[11:0]}, (imm[11:0] != 12'd0), 1'b1};
        J_TYPE: w = '{{imm[20], imm[10:1], imm[11], imm[19:12], b[11:0]},
                      (imm[0] || s < -1048576 || s > 1048574), 1'b1};
        default: w = '{b, 1'b1, 1'b1};
      endcase
      exp_q.push_back(w);
    end
  endfunction

  task automatic rand_req();
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: imm = $urandom;
      2: imm = $urandom & 32'hFFFF_F000;
      default: imm = 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
    endcase
    bus.in_valid    = 1'b1;
    bus.in_base     = $urandom;
    bus.in_imm      = imm;
    bus.in_imm_type = 3'($urandom_range(0, 7));
    bus.in_li       = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    int    n_sent;
    int    cycles;
    logic  acc;
    word_t got;
    word_t w;

    n_vec  = 0;
    n_miss = 0;
    bus.in_valid    = 1'b0;
    bus.in_base     = 32'd0;
    bus.in_imm      = 32'd0;
    bus.in_imm_type = 3'd0;
    bus.in_li       = 1'b0;
    bus.out_ready   = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst out_valid", 40'(bus.out_valid), 40'd0);
    chk("rst out_inst",  40'(bus.out_inst),  40'd0);
    chk("rst out_err",   40'(bus.out_err),   40'd0);
    chk("rst out_last",  40'(bus.out_last),  40'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst in_ready", 40'(bus.in_ready), 40'd1);

    // li expansions
    req("li5", 32'hABCD_E2B3, 32'h1234_5678, 3'd0, 1'b1);
    expect_word("li5 lui",  32'h1234_52B7, 1'b0, 1'b0);
    expect_word("li5 addi", 32'h6782_8293, 1'b0, 1'b1);
    req("li2", 32'h0000_0100, 32'h0000_1800, 3'd0, 1'b1);
    expect_word("li2 lui",  32'h0000_2137, 1'b0, 1'b0);
    expect_word("li2 addi", 32'h8001_0113, 1'b0, 1'b1);
    req("li1", 32'hFFFF_F0FF, 32'hFFFF_F800, 3'd7, 1'b1);
    expect_word("li1 addi", 32'h8000_0093, 1'b0, 1'b1);
    req("li3", 32'h0000_0180, 32'h0000_5000, 3'd0, 1'b1);
    expect_word("li3 lui",  32'h0000_51B7, 1'b0, 1'b1);
    req("li4 wrap", 32'h0000_0200, 32'h7FFF_F800, 3'd0, 1'b1);
    expect_word("li4 lui",  32'h8000_0237, 1'b0, 1'b0);
    expect_word("li4 addi", 32'h8002_0213, 1'b0, 1'b1);

    // field packing and range errors
    req("b m4", 32'h0020_8063, 32'hFFFF_FFFC, B_TYPE, 1'b0);
    expect_word("b m4", 32'hFE20_8EE3, 1'b0, 1'b1);
    req("b 3", 32'h0020_8063, 32'h0000_0003, B_TYPE, 1'b0);
    expect_word("b 3", 32'h0020_8163, 1'b1, 1'b1);
    req("b 4096", 32'h0020_8063, 32'h0000_1000, B_TYPE, 1'b0);
    expect_word("b 4096", 32'h8020_8063, 1'b1, 1'b1);
    req("i 2047", 32'hFFF0_8093, 32'h0000_07FF, I_TYPE, 1'b0);
    expect_word("i 2047", 32'h7FF0_8093, 1'b0, 1'b1);
    req("i 2048", 32'h0000_8093, 32'h0000_0800, I_TYPE, 1'b0);
    expect_word("i 2048", 32'h8000_8093, 1'b1, 1'b1);
    req("u bad", 32'h0000_0537, 32'h1234_5001, U_TYPE, 1'b0);
    expect_word("u bad", 32'h1234_5537, 1'b1, 1'b1);
    req("s m8", 32'h0011_2023, 32'hFFFF_FFF8, S_TYPE, 1'b0);
    expect_word("s m8", 32'hFE11_2C23, 1'b0, 1'b1);
    req("j 2048", 32'h0000_00EF, 32'h0000_0800, J_TYPE, 1'b0);
    expect_word("j 2048", 32'h0010_00EF, 1'b0, 1'b1);
    req("j 2^20", 32'h0000_00EF, 32'h0010_0000, J_TYPE, 1'b0);
    expect_word("j 2^20", 32'h8000_00EF, 1'b1, 1'b1);
    req("bad type", 32'hDEAD_BEEF, 32'h0000_0000, 3'd7, 1'b0);
    expect_word("bad type", 32'hDEAD_BEEF, 1'b1, 1'b1);

    // backpressure on the LUI of a two-word li
    bus.out_ready = 1'b0;
    req("bp", 32'h0000_0280, 32'h1234_5678, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp hold inst", 40'(bus.out_inst), 40'(32'h1234_52B7));
      chk("bp in_ready",  40'(bus.in_ready), 40'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    expect_word("bp lui",  32'h1234_52B7, 1'b0, 1'b0);
    expect_word("bp addi", 32'h6782_8293, 1'b0, 1'b1);

    // async reset while the ADDI is pending
    bus.out_ready = 1'b0;
    req("rst mid", 32'h0000_0280, 32'h1234_5678, 3'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 40'(bus.out_valid), 40'd0);
    chk("mid rst inst",  40'(bus.out_inst),  40'd0);
    chk("mid rst last",  40'(bus.out_last),  40'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    req("post rst", 32'h0000_0180, 32'h0000_5000, 3'd0, 1'b1);
    expect_word("post rst", 32'h0000_51B7, 1'b0, 1'b1);
    chk("no stale addi", 40'(bus.out_valid), 40'd0);

    // random stream with random out_ready against the reference model
    n_sent = 0;
    cycles = 0;
    rand_req();
    while ((n_sent < 1000 || exp_q.size() > 0) && cycles < 30000) begin
      @(negedge clk);
      bus.out_ready = (n_sent >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got = '{bus.out_inst, bus.out_err, bus.out_last};
        if (exp_q.size() == 0) begin
          chk("rnd extra word", 40'(got), 40'h0);
        end else begin
          w = exp_q.pop_front();
          chk("rnd word", 40'(got), 40'(w));
        end
      end
      acc = bus.in_valid & bus.in_ready;
      if (acc) begin
        model(bus.in_base, bus.in_imm, bus.in_imm_type, bus.in_li);
        n_sent++;
      end
      @(posedge clk); #1;
      cycles++;
      if (acc || !bus.in_valid) begin
        if (n_sent < 1000 && $urandom_range(0, 3) != 0) rand_req();
        else bus.in_valid = 1'b0;
      end
    end
    chk("rnd sent",      40'(n_sent),       40'd1000);
    chk("rnd drained",   40'(exp_q.size()), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
